// File: rtl/result_fifo_bank_pkg.sv
// Shared definitions for the result capture buffer: register map, STATUS bit
// positions, write-command bits and the fixed read-back codes.
package result_fifo_bank_pkg;

    localparam int unsigned DATA_W = 32;

    // Per-channel register offsets (address[1:0])
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_LEVEL  = 2'd1,
        REG_STATUS = 2'd2,
        REG_COUNT  = 2'd3
    } reg_sel_e;

    // STATUS read bit positions
    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_OVF   = 2;
    localparam int unsigned ST_UDF   = 3;

    // STATUS write command bits
    localparam int unsigned WB_CLR_OVF = 0;
    localparam int unsigned WB_CLR_UDF = 1;
    localparam int unsigned WB_FLUSH   = 2;

    localparam logic [DATA_W-1:0] EMPTY_READ = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] BAD_ADDR   = 32'hFFFF_FFFC;

    // Assemble the STATUS read word from the per-channel flags
    function automatic logic [DATA_W-1:0] status_word(input logic udf, input logic ovf,
                                                      input logic full, input logic empty);
        logic [DATA_W-1:0] w;
        w           = '0;
        w[ST_UDF]   = udf;
        w[ST_OVF]   = ovf;
        w[ST_FULL]  = full;
        w[ST_EMPTY] = empty;
        return w;
    endfunction

endpackage

// File: rtl/result_fifo_bank_if.sv
// Avalon-MM style slave bus used by the HPS driver to reach the capture buffer.
interface result_fifo_bank_if #(
    parameter int unsigned AW = 4
);
    logic          chipselect;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    modport master (
        output chipselect, read, write, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, read, write, address, writedata,
        output readdata
    );
endinterface

// File: rtl/result_fifo.sv
// Single-channel circular FIFO. Push/pop/flush arrive already qualified by
// the bank; pointers carry one extra wrap bit so full/empty need no counter.
module result_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout_c,
    output logic [$clog2(DEPTH):0]     level_c,
    output logic                       full_c,
    output logic                       empty_c
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Sample storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[IW-1:0]] <= din;
        end
    end

    // Read/write pointers; flush takes priority and empties the channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy and head sample derived from the pointers
    always_comb begin
        empty_c = (wr_ptr == rd_ptr);
        full_c  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
        level_c = wr_ptr - rd_ptr;
        dout_c  = mem[rd_ptr[IW-1:0]];
    end

endmodule

// File: rtl/result_fifo_bank.sv
// Multi-channel result capture buffer read over an Avalon-MM slave port.
// Each channel owns a FIFO plus sticky overflow/underflow flags and an
// accepted-sample counter. Optional feature macro: RESULT_FIFO_BANK_HEX_EN
// adds the hex port holding the last accepted sample per channel.
module result_fifo_bank
    import result_fifo_bank_pkg::*;
#(
    parameter int unsigned NCH   = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(NCH) + 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          en,
    input  logic [NCH-1:0][DW-1:0]  result,
    result_fifo_bank_if.slave       bus
`ifdef RESULT_FIFO_BANK_HEX_EN
    ,
    output logic [NCH-1:0][DW-1:0]  hex
`endif
);
    localparam int unsigned CHW = (AW > 2) ? AW - 2 : 1;
    localparam int unsigned LW  = $clog2(DEPTH) + 1;

    logic                    rd_req;
    logic                    wr_req;
    logic                    rd_data;
    logic                    wr_stat;
    logic [CHW-1:0]          sel_ch;
    reg_sel_e                sel_reg;

    logic [NCH-1:0]          pop;
    logic [NCH-1:0]          push;
    logic [NCH-1:0]          flush;
    logic [NCH-1:0]          ovf_set;
    logic [NCH-1:0]          ovf_clr;
    logic [NCH-1:0]          udf_set;
    logic [NCH-1:0]          udf_clr;
    logic [NCH-1:0]          full;
    logic [NCH-1:0]          empty;
    logic [NCH-1:0]          ovf;
    logic [NCH-1:0]          udf;
    logic [NCH-1:0][DW-1:0]  head;
    logic [NCH-1:0][LW-1:0]  level;
    logic [NCH-1:0][31:0]    count;
    logic [31:0]             rdata_nxt;

    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:3];

    // Bus decode; a read wins over a write in the same cycle
    always_comb begin
        rd_req  = bus.chipselect && bus.read;
        wr_req  = bus.chipselect && bus.write && !bus.read;
        sel_ch  = CHW'(bus.address >> 2);
        sel_reg = reg_sel_e'(bus.address[1:0]);
        rd_data = rd_req && (sel_reg == REG_DATA);
        wr_stat = wr_req && (sel_reg == REG_STATUS);
    end

    // Per-channel push/pop/flush qualification and flag events
    always_comb begin
        logic sel_i;
        logic pop_i;
        logic flush_i;
        pop     = '0;
        push    = '0;
        flush   = '0;
        ovf_set = '0;
        ovf_clr = '0;
        udf_set = '0;
        udf_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_i      = (sel_ch == CHW'(i));
            pop_i      = rd_data && sel_i && !empty[i];
            flush_i    = wr_stat && sel_i && bus.writedata[WB_FLUSH];
            pop[i]     = pop_i;
            flush[i]   = flush_i;
            udf_set[i] = rd_data && sel_i && empty[i];
            push[i]    = en[i] && !flush_i && (!full[i] || pop_i);
            ovf_set[i] = en[i] && !flush_i && full[i] && !pop_i;
            ovf_clr[i] = wr_stat && sel_i && bus.writedata[WB_CLR_OVF];
            udf_clr[i] = wr_stat && sel_i && bus.writedata[WB_CLR_UDF];
        end
    end

    // Channel FIFOs
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        result_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[g]),
            .pop     (pop[g]),
            .flush   (flush[g]),
            .din     (result[g]),
            .dout_c  (head[g]),
            .level_c (level[g]),
            .full_c  (full[g]),
            .empty_c (empty[g])
        );
    end

    // Read data select; out-of-range channels return the bad-address code
    always_comb begin
        rdata_nxt = BAD_ADDR;
        for (int i = 0; i < NCH; i++) begin
            if (sel_ch == CHW'(i)) begin
                case (sel_reg)
                    REG_DATA:   rdata_nxt = empty[i] ? EMPTY_READ : 32'(head[i]);
                    REG_LEVEL:  rdata_nxt = 32'(level[i]);
                    REG_STATUS: rdata_nxt = status_word(udf[i], ovf[i], full[i], empty[i]);
                    REG_COUNT:  rdata_nxt = count[i];
                    default:    rdata_nxt = BAD_ADDR;
                endcase
            end
        end
    end

    // Registered read data, held when no read is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.readdata <= '0;
        end else if (rd_req) begin
            bus.readdata <= rdata_nxt;
        end
    end

    // Sticky flags (a new event outranks a simultaneous clear) and push counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf   <= '0;
            udf   <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ovf_set[i]) begin
                    ovf[i] <= 1'b1;
                end else if (ovf_clr[i]) begin
                    ovf[i] <= 1'b0;
                end
                if (udf_set[i]) begin
                    udf[i] <= 1'b1;
                end else if (udf_clr[i]) begin
                    udf[i] <= 1'b0;
                end
                if (push[i]) begin
                    count[i] <= count[i] + 32'd1;
                end
            end
        end
    end

`ifdef RESULT_FIFO_BANK_HEX_EN
    // Last accepted sample per channel; flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) begin
                    hex[i] <= result[i];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_result_fifo_bank.sv
// Bench for result_fifo_bank: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_result_fifo_bank;
    import result_fifo_bank_pkg::*;

    localparam int unsigned NCH   = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = $clog2(NCH) + 2;

    typedef logic [NCH-1:0][DW-1:0] res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [NCH-1:0] en;
    res_t       result;
`ifdef RESULT_FIFO_BANK_HEX_EN
    res_t       hex;
`endif

    result_fifo_bank_if #(.AW(AW)) bus ();

    result_fifo_bank #(
        .NCH   (NCH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .result (result),
        .bus    (bus)
`ifdef RESULT_FIFO_BANK_HEX_EN
        ,
        .hex    (hex)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0]   mq [NCH][$];
    bit            m_ovf [NCH];
    bit            m_udf [NCH];
    int unsigned   m_cnt [NCH];
    logic [DW-1:0] m_hex [NCH];
    logic [31:0]   m_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            m_ovf[i] = 0;
            m_udf[i] = 0;
            m_cnt[i] = 0;
            m_hex[i] = '0;
        end
        m_rd = '0;
    endtask

    // Apply the effect of the coming clock edge using the driven inputs
    task automatic model_edge();
        bit  rdq;
        bit  wrq;
        int  ch;
        int  fl;
        logic [1:0] rg;
        rdq = bus.chipselect && bus.read;
        wrq = bus.chipselect && bus.write && !bus.read;
        ch  = int'(bus.address >> 2);
        rg  = bus.address[1:0];
        fl  = -1;
        if (rdq) begin
            if (ch >= NCH) begin
                m_rd = 32'hFFFF_FFFC;
            end else begin
                case (rg)
                    2'd0: begin
                        if (mq[ch].size() == 0) begin
                            m_rd = 32'hFFFF_FFFF;
                            m_udf[ch] = 1;
                        end else begin
                            m_rd = mq[ch].pop_front();
                        end
                    end
                    2'd1: m_rd = 32'(mq[ch].size());
                    2'd2: m_rd = {28'd0, m_udf[ch], m_ovf[ch],
                                  mq[ch].size() == DEPTH, mq[ch].size() == 0};
                    default: m_rd = m_cnt[ch];
                endcase
            end
        end else if (wrq && ch < NCH && rg == 2'd2) begin
            if (bus.writedata[0]) m_ovf[ch] = 0;
            if (bus.writedata[1]) m_udf[ch] = 0;
            if (bus.writedata[2]) begin
                mq[ch].delete();
                fl = ch;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (en[i] && i != fl) begin
                if (mq[i].size() < DEPTH) begin
                    mq[i].push_back(32'(result[i]));
                    m_cnt[i] = m_cnt[i] + 1;
                    m_hex[i] = result[i];
                end else begin
                    m_ovf[i] = 1;
                end
            end
        end
    endtask

    // One clock cycle: drive, model, advance, compare
    task automatic cyc(input logic [NCH-1:0] e, input res_t r, input logic cs,
                       input logic rd, input logic wr, input int ch, input int rg,
                       input logic [31:0] wd);
        en             = e;
        result         = r;
        bus.chipselect = cs;
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = AW'((ch << 2) | (rg & 3));
        bus.writedata  = wd;
        model_edge();
        @(posedge clk);
        #1;
        chk("rdata", bus.readdata, m_rd);
`ifdef RESULT_FIFO_BANK_HEX_EN
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("hex%0d", i), 32'(hex[i]), 32'(m_hex[i]));
        end
`endif
    endtask

    task automatic push1(input int ch, input logic [DW-1:0] v);
        res_t r;
        r     = '0;
        r[ch] = v;
        cyc(NCH'(1 << ch), r, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
    endtask

    task automatic rdreg(input int ch, input int rg);
        cyc('0, '0, 1'b1, 1'b1, 1'b0, ch, rg, 32'd0);
    endtask

    task automatic wrreg(input int ch, input int rg, input logic [31:0] wd);
        cyc('0, '0, 1'b1, 1'b0, 1'b1, ch, rg, wd);
    endtask

    initial begin
        res_t r;
        logic [NCH-1:0] e;
        en             = '0;
        result         = '0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_rdata", bus.readdata, 32'd0);

        // Reset state of every channel
        for (int c = 0; c < NCH; c++) begin
            rdreg(c, 1); chk($sformatf("rst_level%0d", c), bus.readdata, 32'd0);
            rdreg(c, 2); chk($sformatf("rst_status%0d", c), bus.readdata, 32'd1);
            rdreg(c, 3); chk($sformatf("rst_count%0d", c), bus.readdata, 32'd0);
        end

        // Three pushes then back-to-back pops on ch1
        push1(1, 8'h11); push1(1, 8'h22); push1(1, 8'h33);
        rdreg(1, 0); chk("t1_d0", bus.readdata, 32'h11);
        rdreg(1, 0); chk("t1_d1", bus.readdata, 32'h22);
        rdreg(1, 0); chk("t1_d2", bus.readdata, 32'h33);
        rdreg(1, 1); chk("t1_level", bus.readdata, 32'd0);
        rdreg(1, 3); chk("t1_count", bus.readdata, 32'd3);

        // Overfill ch0
        for (int k = 1; k <= 6; k++) push1(0, 8'(k));
        rdreg(0, 1); chk("t2_level", bus.readdata, 32'd4);
        rdreg(0, 2); chk("t2_status", bus.readdata, 32'h6);
        rdreg(0, 3); chk("t2_count", bus.readdata, 32'd4);
        wrreg(0, 2, 32'h1);
        rdreg(0, 2); chk("t2_ovf_clr", bus.readdata, 32'h2);

        // Underflow and bad channel
        rdreg(2, 0); chk("t3_empty_read", bus.readdata, 32'hFFFF_FFFF);
        rdreg(2, 2); chk("t3_udf", bus.readdata, 32'h9);
        rdreg(3, 0); chk("t3_bad_addr", bus.readdata, 32'hFFFF_FFFC);

        // Push and pop together while full
        r = '0; r[0] = 8'h55;
        cyc(3'b001, r, 1'b1, 1'b1, 1'b0, 0, 0, 32'd0);
        chk("t4_oldest", bus.readdata, 32'h01);
        rdreg(0, 1); chk("t4_level", bus.readdata, 32'd4);
        rdreg(0, 2); chk("t4_status", bus.readdata, 32'h2);

        // Flush with a simultaneous push
        wrreg(2, 2, 32'h2);
        push1(2, 8'hA1); push1(2, 8'hA2);
        r = '0; r[2] = 8'hA3;
        cyc(3'b100, r, 1'b1, 1'b0, 1'b1, 2, 2, 32'h4);
        rdreg(2, 1); chk("t5_level", bus.readdata, 32'd0);
        rdreg(2, 3); chk("t5_count", bus.readdata, 32'd2);
        rdreg(2, 2); chk("t5_status", bus.readdata, 32'h1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int op;
            int ch;
            int rg;
            logic cs;
            for (int i = 0; i < NCH; i++) begin
                e[i] = ($urandom_range(0, 9) < 4);
                r[i] = DW'($urandom);
            end
            op = int'($urandom_range(0, 9));
            ch = int'($urandom_range(0, 3));
            rg = $urandom_range(0, 1) ? 0 : int'($urandom_range(0, 3));
            cs = ($urandom_range(0, 7) != 0);
            if (op <= 4)      cyc(e, r, cs, 1'b1, 1'b0, ch, rg, $urandom);
            else if (op <= 6) cyc(e, r, cs, 1'b0, 1'b1, ch, 2, $urandom & 32'h7);
            else if (op == 7) cyc(e, r, cs, 1'b1, 1'b1, ch, rg, $urandom);
            else              cyc(e, r, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
        end

        // Asynchronous reset in the middle of traffic
        push1(0, 8'h5A); push1(1, 8'hA5);
        rdreg(1, 3);
        en = '0; result = '0; bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst2_rdata", bus.readdata, 32'd0);
`ifdef RESULT_FIFO_BANK_HEX_EN
        for (int i = 0; i < NCH; i++) chk($sformatf("rst2_hex%0d", i), 32'(hex[i]), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            rdreg(c, 1); chk($sformatf("rst2_level%0d", c), bus.readdata, 32'd0);
            rdreg(c, 3); chk($sformatf("rst2_count%0d", c), bus.readdata, 32'd0);
            rdreg(c, 2); chk($sformatf("rst2_status%0d", c), bus.readdata, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
